// File: rtl/adder_vector_recorder.sv
// rtl/adder_vector_recorder.sv - buffers {a,b,y} adder vectors and drains them as a/b/y word stream
// Optional RECORDER_CHECK_EN: checks y == a+b on every captured sample.
module adder_vector_recorder #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 25,
  parameter int CNT_W  = 5,
  parameter int ERR_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [DATA_W:0]   in_y,
  input  logic              dump_start,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W:0]   dump_data,
  output logic              dump_done,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic [ERR_W-1:0]  err_count,
  output logic              mismatch
);

  typedef enum logic [1:0] {CAPTURE, DUMP, DONE} state_t;

  state_t             state;
  logic [DATA_W-1:0]  mem_a [DEPTH];
  logic [DATA_W-1:0]  mem_b [DEPTH];
  logic [DATA_W:0]    mem_y [DEPTH];
  logic [CNT_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   rd_ptr;
  logic [1:0]         sub;
  logic               accept;
  logic [CNT_W-1:0]   count_nxt;
  logic [DATA_W:0]    rd_word;

  assign accept    = (state == CAPTURE) && in_valid && in_ready;
  assign count_nxt = count + CNT_W'(accept);
  assign full      = (count == CNT_W'(DEPTH));

  // Buffer storage has no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
      mem_y[wr_ptr] <= in_y;
    end
  end

  always_comb begin
    rd_word = '0;
    case (sub)
      2'd0:    rd_word = {1'b0, mem_a[rd_ptr]};
      2'd1:    rd_word = {1'b0, mem_b[rd_ptr]};
      default: rd_word = mem_y[rd_ptr];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= CAPTURE;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      sub        <= 2'd0;
      in_ready   <= 1'b1;
      dump_valid <= 1'b0;
      dump_data  <= '0;
      dump_done  <= 1'b0;
    end else begin
      dump_done <= 1'b0;
      case (state)
        CAPTURE: begin
          if (accept) wr_ptr <= wr_ptr + CNT_W'(1);
          count <= count_nxt;
          // A sample accepted alongside dump_start is already counted in count_nxt.
          if (dump_start && (count_nxt != '0)) begin
            state    <= DUMP;
            in_ready <= 1'b0;
            rd_ptr   <= '0;
            sub      <= 2'd0;
          end else begin
            in_ready <= (count_nxt < CNT_W'(DEPTH));
          end
        end
        DUMP: begin
          if (!dump_valid || dump_ready) begin
            if (rd_ptr != count) begin
              dump_valid <= 1'b1;
              dump_data  <= rd_word;
              if (sub == 2'd2) begin
                sub    <= 2'd0;
                rd_ptr <= rd_ptr + CNT_W'(1);
              end else begin
                sub <= sub + 2'd1;
              end
            end else if (dump_valid) begin
              dump_valid <= 1'b0;
              dump_done  <= 1'b1;
              state      <= DONE;
            end
          end
        end
        DONE: begin
          count    <= '0;
          wr_ptr   <= '0;
          rd_ptr   <= '0;
          sub      <= 2'd0;
          in_ready <= 1'b1;
          state    <= CAPTURE;
        end
        default: state <= CAPTURE;
      endcase
    end
  end

`ifdef RECORDER_CHECK_EN
  logic [DATA_W:0] sum;
  assign sum = {1'b0, in_a} + {1'b0, in_b};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
      mismatch  <= 1'b0;
    end else if (accept && (in_y != sum)) begin
      mismatch <= 1'b1;
      if (err_count != '1) err_count <= err_count + ERR_W'(1);
    end
  end
`else
  assign err_count = '0;
  assign mismatch  = 1'b0;
`endif

endmodule

// File: tb/tb_adder_vector_recorder.sv
// tb/tb_adder_vector_recorder.sv - directed scoreboard bench for adder_vector_recorder
module tb_adder_vector_recorder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic [8:0]  in_y = '0;
  logic        dump_start = 1'b0;
  logic        dump_valid;
  logic        dump_ready = 1'b0;
  logic [8:0]  dump_data;
  logic        dump_done;
  logic [4:0]  count;
  logic        full;
  logic [15:0] err_count;
  logic        mismatch;

  int checks = 0;
  int errors = 0;
  int exp_err = 0;
  logic [8:0] q[$];

  always #5 clk = ~clk;

  adder_vector_recorder dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_y(in_y),
    .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_data(dump_data), .dump_done(dump_done),
    .count(count), .full(full), .err_count(err_count), .mismatch(mismatch)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [8:0] y);
    int g = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_y = y;
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (in_ready) begin
      q.push_back({1'b0, a});
      q.push_back({1'b0, b});
      q.push_back(y);
`ifdef RECORDER_CHECK_EN
      if (y != ({1'b0, a} + {1'b0, b})) exp_err++;
`endif
    end else begin
      chk("send_timeout", {31'd0, in_ready}, 32'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic fill(input int n, input int kind);
    logic [7:0] a, b;
    for (int i = 0; i < n; i++) begin
      a = (kind == 0) ? 8'(i) : 8'(i * 37 + 11);
      b = (kind == 0) ? 8'(i) : 8'(i * 53 + 5);
      send(a, b, {1'b0, a} + {1'b0, b});
    end
  endtask

  task automatic start_dump();
    dump_start = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
  endtask

  task automatic drain(input bit toggle, input int stop_words);
    int words = 0;
    int pulses = 0;
    int cyc = 0;
    int n_exp = q.size();
    bit held = 1'b0;
    logic [8:0] hd = '0;
    logic [8:0] ew;
    while (cyc < 400) begin
      if (dump_done) pulses++;
      if (pulses > 0) break;
      if (held) begin
        chk("stall_valid", {31'd0, dump_valid}, 32'd1);
        chk("stall_stable", {23'd0, dump_data}, {23'd0, hd});
      end
      dump_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (dump_valid && dump_ready) begin
        if (q.size() == 0) begin
          chk("queue_underflow", 32'd0, 32'd1);
        end else begin
          ew = q.pop_front();
          chk("dump_word", {23'd0, dump_data}, {23'd0, ew});
        end
        words++;
        held = 1'b0;
      end else if (dump_valid) begin
        held = 1'b1;
        hd = dump_data;
      end
      @(negedge clk);
      cyc++;
      if (stop_words > 0 && words == stop_words) begin
        dump_ready = 1'b0;
        return;
      end
    end
    dump_ready = 1'b0;
    chk("dump_words", words, n_exp);
    chk("done_pulse", pulses, 1);
    @(negedge clk);
    chk("done_single", {31'd0, dump_done}, 32'd0);
    chk("post_count", {27'd0, count}, 32'd0);
    chk("post_ready", {31'd0, in_ready}, 32'd1);
    chk("post_valid", {31'd0, dump_valid}, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_count", {27'd0, count}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_valid", {31'd0, dump_valid}, 32'd0);
    chk("rst_data", {23'd0, dump_data}, 32'd0);
    chk("rst_done", {31'd0, dump_done}, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_err", {16'd0, err_count}, 32'd0);
    chk("rst_mismatch", {31'd0, mismatch}, 32'd0);

    // fill to capacity, then offer a 26th sample
    fill(25, 0);
    chk("fill_count", {27'd0, count}, 32'd25);
    chk("fill_full", {31'd0, full}, 32'd1);
    chk("fill_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1; in_a = 8'h55; in_b = 8'h01; in_y = 9'h056;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    chk("overflow_count", {27'd0, count}, 32'd25);
    chk("overflow_ready", {31'd0, in_ready}, 32'd0);

    start_dump();
    drain(1'b0, 0);

    // stalled dump
    fill(25, 1);
    start_dump();
    drain(1'b1, 0);

    // dump_start on empty buffer is ignored
    start_dump();
    repeat (4) begin
      chk("empty_valid", {31'd0, dump_valid}, 32'd0);
      chk("empty_done", {31'd0, dump_done}, 32'd0);
      @(negedge clk);
    end
    chk("empty_ready", {31'd0, in_ready}, 32'd1);

    // sample and dump_start in the same cycle
    in_valid = 1'b1; in_a = 8'hFF; in_b = 8'h01; in_y = 9'h100; dump_start = 1'b1;
    chk("same_ready", {31'd0, in_ready}, 32'd1);
    q.push_back(9'h0FF); q.push_back(9'h001); q.push_back(9'h100);
    @(negedge clk);
    in_valid = 1'b0; dump_start = 1'b0;
    chk("same_blocked", {31'd0, in_ready}, 32'd0);
    drain(1'b0, 0);

    // checker vectors
    send(8'h03, 8'h04, 9'h007);
    send(8'h03, 8'h04, 9'h008);
    send(8'hFF, 8'hFF, 9'h1FE);
    send(8'h01, 8'h01, 9'h000);
    chk("chk_err", {16'd0, err_count}, exp_err);
    chk("chk_mismatch", {31'd0, mismatch}, {31'd0, exp_err != 0});
    start_dump();
    drain(1'b0, 0);
    chk("chk_err_kept", {16'd0, err_count}, exp_err);

    // reset in the middle of a dump
    fill(25, 0);
    start_dump();
    drain(1'b0, 10);
    rst = 1'b1;
    #1;
    chk("midrst_valid", {31'd0, dump_valid}, 32'd0);
    chk("midrst_count", {27'd0, count}, 32'd0);
    chk("midrst_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_err", {16'd0, err_count}, 32'd0);
    chk("midrst_mismatch", {31'd0, mismatch}, 32'd0);
    q.delete();
    exp_err = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fill(6, 1);
    chk("refill_count", {27'd0, count}, 32'd6);
    start_dump();
    drain(1'b1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
